// File: rtl/rosc_meas_pkg.sv
// Shared types and default sizes for the ring-oscillator measurement stage.
package rosc_meas_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WIN_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DRAIN_CYC       = DEF_SYNC_STAGES + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COUNT,
        ST_DRAIN,
        ST_DONE
    } meas_state_e;

    // Drain must outlast the synchronizer so no in-flight edge leaks into the next run.
    function automatic int drain_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/rosc_sync_edge.sv
// Multi-flop synchronizer for the async oscillator output plus a one-cycle rising-edge pulse.
module rosc_sync_edge
    import rosc_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic ASYNC_IN,
    output logic EDGE
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign EDGE = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rosc_meas_counter.sv
// Enables a ring oscillator, counts its rising edges over a window of CLK cycles,
// and hands the saturating count to the consumer with a valid/ack handshake.
module rosc_meas_counter
    import rosc_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WIN_W       = DEF_WIN_W,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ROSC_OUT,
    input  logic             MEAS_REQ,
    input  logic             MEAS_ABORT,
    input  logic [WIN_W-1:0] WIN_CYCLES,
    input  logic             MEAS_ACK,
    output logic             EN_ROSC,
    output logic             BUSY,
    output logic             MEAS_VALID,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVERFLOW
);

    localparam int               DRAIN_N   = drain_cycles(SYNC_STAGES);
    localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(DRAIN_N - 1);

    meas_state_e      state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             en_rosc_q, en_rosc_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             edge_pulse;

    rosc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .ASYNC_IN (ROSC_OUT),
        .EDGE     (edge_pulse)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        win_d      = win_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (MEAS_REQ) begin
                    state_d    = ST_WARMUP;
                    win_d      = WIN_CYCLES;
                    timer_d    = SETTLE_LD;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_WARMUP: begin
                if (timer_q == '0) begin
                    if (win_q == '0) begin
                        state_d = ST_DRAIN;
                        timer_d = DRAIN_LD;
                    end else begin
                        state_d = ST_COUNT;
                        timer_d = win_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_COUNT: begin
                if (edge_pulse) begin
                    if (&count_q) overflow_d = 1'b1;
                    else          count_d    = count_q + 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = ST_DRAIN;
                    timer_d = DRAIN_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (timer_q == '0) state_d = ST_DONE;
                else               timer_d = timer_q - 1'b1;
            end
            ST_DONE: begin
                if (MEAS_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over every other transition; in DONE it is equivalent to an ack.
        if (MEAS_ABORT && state_q != ST_IDLE) state_d = ST_IDLE;

        en_rosc_d = (state_d == ST_WARMUP) || (state_d == ST_COUNT);
        busy_d    = (state_d != ST_IDLE);
        valid_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            win_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            en_rosc_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            win_q      <= win_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            en_rosc_q  <= en_rosc_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign EN_ROSC    = en_rosc_q;
    assign BUSY       = busy_q;
    assign MEAS_VALID = valid_q;
    assign COUNT      = count_q;
    assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_rosc_meas_counter.sv
// Directed bench for rosc_meas_counter: a 16-bit instance and an 8-bit instance share stimulus.
module tb_rosc_meas_counter;

    logic        clk;
    logic        rstn;
    logic        rosc_out;
    logic        req;
    logic        abort_i;
    logic [15:0] win;
    logic        ack;

    logic        en, busy, valid, ovf;
    logic [15:0] count;
    logic        en2, busy2, valid2, ovf2;
    logic [7:0]  count2;

    int n_tests;
    int n_fail;
    int rosc_half;

    rosc_meas_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RSTN(rstn), .ROSC_OUT(rosc_out), .MEAS_REQ(req), .MEAS_ABORT(abort_i),
        .WIN_CYCLES(win), .MEAS_ACK(ack), .EN_ROSC(en), .BUSY(busy), .MEAS_VALID(valid),
        .COUNT(count), .OVERFLOW(ovf)
    );

    rosc_meas_counter #(.CNT_W(8), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut8 (
        .CLK(clk), .RSTN(rstn), .ROSC_OUT(rosc_out), .MEAS_REQ(req), .MEAS_ABORT(abort_i),
        .WIN_CYCLES(win), .MEAS_ACK(ack), .EN_ROSC(en2), .BUSY(busy2), .MEAS_VALID(valid2),
        .COUNT(count2), .OVERFLOW(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator edges land at 3 mod 10 ns, never on a CLK edge (5 mod 10 ns).
    initial begin
        rosc_out = 1'b0;
        #3;
        forever begin
            if (rosc_half == 0) begin
                rosc_out = 1'b0;
                #10;
            end else begin
                #(rosc_half);
                rosc_out = ~rosc_out;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) tick;
        n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        n_tests++; if ({en2, busy2, valid2, ovf2, count2} !== 12'd0) begin
            n_fail++; $display("FAIL reset_dut8: got %h expected 0", {en2, busy2, valid2, ovf2, count2});
        end
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_window_count;
        int waited;
        rosc_half = 40;
        win = 16'd800;
        req = 1'b1;
        tick;
        req = 1'b0;
        waited = 0;
        while (valid !== 1'b1 && waited < 1000) begin tick; waited++; end
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL win800_valid: got %b expected 1 within 1000 cycles", valid); end
        n_tests++; if (count < 16'd99 || count > 16'd101) begin n_fail++; $display("FAIL win800_count: got %0d expected 100+/-1", count); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL win800_ovf: got %b expected 0", ovf); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL win800_idle: busy got %b expected 0", busy); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL win800_valid_drop: got %b expected 0", valid); end
    endtask

    task automatic test_latency;
        logic exp_en, exp_v, exp_b;
        rosc_half = 0;
        win = 16'd10;
        req = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick;
            req = 1'b0;
            exp_en = (k <= 18);
            exp_v  = (k >= 22) && (k <= 25);
            exp_b  = (k <= 25);
            n_tests++; if (en !== exp_en) begin n_fail++; $display("FAIL lat_en cyc%0d: got %b expected %b", k, en, exp_en); end
            n_tests++; if (valid !== exp_v) begin n_fail++; $display("FAIL lat_valid cyc%0d: got %b expected %b", k, valid, exp_v); end
            n_tests++; if (busy !== exp_b) begin n_fail++; $display("FAIL lat_busy cyc%0d: got %b expected %b", k, busy, exp_b); end
            ack = (k == 25);
        end
        ack = 1'b0;
    endtask

    task automatic test_win_zero;
        rosc_half = 40;
        win = 16'd0;
        req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            req = 1'b0;
            if (k == 11) begin
                n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL win0_early_valid: got %b expected 0", valid); end
            end
            if (k == 10) begin
                n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL win0_en_drain: got %b expected 0", en); end
            end
        end
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL win0_valid: got %b expected 1", valid); end
        n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL win0_count: got %0d expected 0", count); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
    endtask

    task automatic test_overflow;
        int waited;
        rosc_half = 20;
        win = 16'd2000;
        req = 1'b1;
        tick;
        req = 1'b0;
        waited = 0;
        while (valid2 !== 1'b1 && waited < 2100) begin tick; waited++; end
        n_tests++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1 within 2100 cycles", valid2); end
        n_tests++; if (count2 !== 8'hFF) begin n_fail++; $display("FAIL ovf_count8: got %0d expected 255", count2); end
        n_tests++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag8: got %b expected 1", ovf2); end
        n_tests++; if (count < 16'd499 || count > 16'd501) begin n_fail++; $display("FAIL ovf_count16: got %0d expected 500+/-1", count); end
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flag16: got %b expected 0", ovf); end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        n_tests++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_idle: got %b expected 1", ovf2); end
        req = 1'b1;
        tick;
        req = 1'b0;
        n_tests++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf2); end
        n_tests++; if (count2 !== 8'd0) begin n_fail++; $display("FAIL ovf_count_clear: got %0d expected 0", count2); end
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL ovf_rerun_busy: got %b expected 1", busy2); end
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL ovf_abort_idle: got %b expected 0", busy2); end
    endtask

    task automatic test_abort;
        int seen_valid;
        rosc_half = 40;
        win = 16'd100;
        req = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick;
            req = 1'b0;
        end
        n_tests++; if (en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre: en/busy got %b%b expected 11", en, busy); end
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL abort_en: got %b expected 0", en); end
        seen_valid = 0;
        for (int k = 0; k < 150; k++) begin
            if (valid !== 1'b0 || busy !== 1'b0) seen_valid++;
            tick;
        end
        n_tests++; if (seen_valid != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d active cycles expected 0", seen_valid); end

        req = 1'b1;
        tick;
        req = 1'b0;
        tick;
        tick;
        n_tests++; if (en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: en got %b expected 1", en); end
        rstn = 1'b0;
        tick;
        n_tests++; if ({en, busy, valid, ovf} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 0000", {en, busy, valid, ovf}); end
        n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        rstn = 1'b1;
        repeat (30) tick;
        n_tests++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard: valid/busy got %b%b expected 00", valid, busy); end
    endtask

    task automatic test_back_to_back;
        rosc_half = 0;
        win = 16'd2;
        req = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            tick;
            if (k == 13) begin
                n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got %b expected 0", valid); end
            end
            if (k == 14) begin
                n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b expected 1", valid); end
                ack = 1'b1;
            end
            if (k == 15) begin
                ack = 1'b0;
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_req_dropped: busy got %b expected 0", busy); end
            end
            if (k == 16) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept: busy got %b expected 1", busy); end
            end
            if (k == 28) begin
                n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early2: got %b expected 0", valid); end
            end
        end
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b expected 1", valid); end
        req = 1'b0;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        tick;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_final_idle: busy got %b expected 0", busy); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rosc_half = 0;
        rstn      = 1'b0;
        req       = 1'b0;
        abort_i   = 1'b0;
        win       = 16'd0;
        ack       = 1'b0;

        test_reset;
        test_window_count;
        test_latency;
        test_win_zero;
        test_overflow;
        test_abort;
        test_back_to_back;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
